// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture controller.
//   cap_state_t : capture FSM state encoding
//   DATA_W_DEF  : default ADC sample width
//   CNT_W_DEF   : default width of offset and sample counters
//   DS_W        : width of the optional downsample ratio input
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int DATA_W_DEF = 10;
  localparam int CNT_W_DEF  = 32;
  localparam int DS_W       = 16;

endpackage

// File: rtl/capture_delay_counter.sv
// Loadable down-counter for the trigger offset.
//   adc_clk, reset : clock, asynchronous active-high reset
//   load, load_val : load the counter with load_val (has priority over dec)
//   dec            : decrement by one; holds at zero instead of wrapping
//   count, zero    : current value and (count == 0) flag
module capture_delay_counter #(
  parameter int CNT_W = 32
) (
  input  logic             adc_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: on a capture request waits trigger_offset_i cycles,
// then streams max_samples_i registered ADC samples into a FIFO, stopping
// early on FIFO full (sticky overflow) or when the request is withdrawn.
// Ports:
//   adc_clk, reset            : clock, asynchronous active-high reset
//   adc_data_i                : ADC sample, new every cycle
//   capture_go_i              : capture request, held until capture_done_o
//   capture_done_o            : capture complete, held until go drops
//   trigger_offset_i          : cycles from go to first stored sample
//   max_samples_i             : samples to store per capture (0 = none)
//   fifo_full_i               : FIFO cannot accept a write
//   fifo_wr_en_o/_data_o      : FIFO write strobe and registered sample
//   busy_o                    : delaying or capturing
//   overflow_o                : capture ended by FIFO full (sticky)
//   sample_count_o            : samples written in current/last capture
// Build option: define ADC_CAPTURE_DOWNSAMPLE_EN to add downsample_i, which
// writes only every downsample_i+1 CAPTURE cycles (first on CAPTURE entry).
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              adc_clk,
  input  logic              reset,
`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
  input  logic [DS_W-1:0]   downsample_i,
`endif
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              capture_go_i,
  output logic              capture_done_o,
  input  logic [CNT_W-1:0]  trigger_offset_i,
  input  logic [CNT_W-1:0]  max_samples_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_wr_data_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  sample_count_o
);

  cap_state_t       state, next_state;
  logic [CNT_W-1:0] max_lat;
  logic [CNT_W-1:0] dly_count;
  logic [CNT_W-1:0] count_inc;
  logic             dly_zero;
  logic             dly_load, dly_dec;
  logic             load_cfg, do_write, set_ovf;
  logic             write_slot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign count_inc = sat_inc(sample_count_o);

  // The offset is latched by loading it straight into the delay counter.
  capture_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .adc_clk  (adc_clk),
    .reset    (reset),
    .load     (dly_load),
    .dec      (dly_dec),
    .load_val (trigger_offset_i),
    .count    (dly_count),
    .zero     (dly_zero)
  );

`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
  logic [DS_W-1:0] ds_lat, ds_cnt;

  // ds_cnt is zero on CAPTURE entry so the first CAPTURE cycle writes.
  assign write_slot = (ds_cnt == '0);

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      ds_lat <= '0;
      ds_cnt <= '0;
    end else begin
      if (load_cfg) ds_lat <= downsample_i;
      if (state != ST_CAPTURE) ds_cnt <= '0;
      else if (do_write)       ds_cnt <= ds_lat;
      else if (ds_cnt != '0)   ds_cnt <= ds_cnt - DS_W'(1);
    end
  end
`else
  assign write_slot = 1'b1;
`endif

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_cfg   = 1'b0;
    dly_load   = 1'b0;
    dly_dec    = 1'b0;
    do_write   = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture_go_i) begin
          load_cfg = 1'b1;
          dly_load = 1'b1;
          if (max_samples_i == '0)          next_state = ST_DONE;
          else if (trigger_offset_i != '0)  next_state = ST_DELAY;
          else                              next_state = ST_CAPTURE;
        end
      end
      ST_DELAY: begin
        // Leaving at count 1 puts the first write offset+1 cycles after go.
        if (!capture_go_i)                             next_state = ST_IDLE;
        else if (dly_zero || dly_count == CNT_W'(1))   next_state = ST_CAPTURE;
        else                                           dly_dec    = 1'b1;
      end
      ST_CAPTURE: begin
        if (!capture_go_i) begin
          next_state = ST_IDLE;
        end else if (fifo_full_i) begin
          set_ovf    = 1'b1;
          next_state = ST_DONE;
        end else if (write_slot) begin
          do_write = 1'b1;
          if (count_inc >= max_lat) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!capture_go_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output register stage: status outputs reflect the state one cycle later.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      max_lat        <= '0;
      fifo_wr_en_o   <= 1'b0;
      fifo_wr_data_o <= '0;
      sample_count_o <= '0;
      overflow_o     <= 1'b0;
      busy_o         <= 1'b0;
      capture_done_o <= 1'b0;
    end else begin
      fifo_wr_en_o   <= do_write;
      busy_o         <= (state == ST_DELAY) || (state == ST_CAPTURE);
      capture_done_o <= (state == ST_DONE);
      if (load_cfg) begin
        max_lat        <= max_samples_i;
        sample_count_o <= '0;
        overflow_o     <= 1'b0;
      end
      if (do_write) begin
        fifo_wr_data_o <= adc_data_i;
        sample_count_o <= count_inc;
      end
      if (set_ovf) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed scoreboard bench for adc_capture_ctrl. Expected FIFO writes are
// queued (edge number + sample) as stimulus is driven and popped by a
// negedge monitor whenever fifo_wr_en_o is seen.
module tb_adc_capture_ctrl;

  logic        adc_clk = 1'b0;
  logic        reset;
  logic [9:0]  adc_data;
  logic        go;
  logic        done;
  logic [31:0] offset;
  logic [31:0] max_s;
  logic        full;
  logic        wr_en;
  logic [9:0]  wr_data;
  logic        busy;
  logic        ovf;
  logic [31:0] count;
`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
  logic [15:0] downsample;
`endif

  typedef struct {
    int unsigned edge_no;
    logic [9:0]  data;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  int unsigned edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  adc_capture_ctrl dut (
    .adc_clk          (adc_clk),
    .reset            (reset),
`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
    .downsample_i     (downsample),
`endif
    .adc_data_i       (adc_data),
    .capture_go_i     (go),
    .capture_done_o   (done),
    .trigger_offset_i (offset),
    .max_samples_i    (max_s),
    .fifo_full_i      (full),
    .fifo_wr_en_o     (wr_en),
    .fifo_wr_data_o   (wr_data),
    .busy_o           (busy),
    .overflow_o       (ovf),
    .sample_count_o   (count)
  );

  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: fresh ADC sample, optionally expect it written at the next edge.
  task automatic tick(input bit expect_wr);
    adc_data = 10'($urandom);
    if (expect_wr) sb.push_back('{edge_cnt + 1, adc_data});
    @(posedge adc_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  always @(negedge adc_clk) begin
    if (wr_en) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed data=%0h at edge %0d expected no write", wr_data, edge_cnt);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_edge", 64'(edge_cnt), 64'(mon_e.edge_no));
        chk("wr_data", 64'(wr_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    go       = 1'b0;
    full     = 1'b0;
    offset   = '0;
    max_s    = '0;
    adc_data = '0;
`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
    downsample = '0;
`endif
    ticks(2);
    chk("rst_done",  64'(done),    64'd0);
    chk("rst_wr_en", 64'(wr_en),   64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_ovf",   64'(ovf),     64'd0);
    chk("rst_data",  64'(wr_data), 64'd0);
    chk("rst_count", 64'(count),   64'd0);
    reset = 1'b0;
    ticks(2);

    // offset 0, four samples: writes on edges 1..4, done after edge 5
    offset = 32'd0; max_s = 32'd4; go = 1'b1;
    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("a_count4", 64'(count), 64'd4);
    chk("a_done_early", 64'(done), 64'd0);
    tick(1'b0);
    chk("a_done", 64'(done), 64'd1);
    chk("a_busy_off", 64'(busy), 64'd0);
    go = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("a_done_clr", 64'(done), 64'd0);
    chk("a_sb_empty", 64'(sb.size()), 64'd0);

    // offset 3, two samples; config inputs change after go and must be ignored
    offset = 32'd3; max_s = 32'd2; go = 1'b1;
    tick(1'b0);
    chk("b_busy_e0", 64'(busy), 64'd0);
    offset = 32'd0; max_s = 32'd100;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0);
      chk("b_busy_delay", 64'(busy), 64'd1);
    end
    tick(1'b1);
    tick(1'b1);
    chk("b_busy_e5", 64'(busy), 64'd1);
    tick(1'b0);
    chk("b_busy_e6", 64'(busy), 64'd0);
    chk("b_done", 64'(done), 64'd1);
    chk("b_count", 64'(count), 64'd2);
    go = 1'b0;
    ticks(2);
    chk("b_sb_empty", 64'(sb.size()), 64'd0);

    // FIFO full on third write cycle
    offset = 32'd0; max_s = 32'd8; go = 1'b1;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    full = 1'b1;
    tick(1'b0);
    chk("c_ovf", 64'(ovf), 64'd1);
    chk("c_no_wr", 64'(wr_en), 64'd0);
    full = 1'b0;
    tick(1'b0);
    chk("c_done", 64'(done), 64'd1);
    chk("c_count", 64'(count), 64'd2);
    go = 1'b0;
    ticks(2);

    // zero samples: done next cycle, held while go high; go clears overflow
    offset = 32'd5; max_s = 32'd0; go = 1'b1;
    tick(1'b0);
    chk("d_ovf_clr", 64'(ovf), 64'd0);
    chk("d_count_clr", 64'(count), 64'd0);
    chk("d_done_e0", 64'(done), 64'd0);
    tick(1'b0);
    chk("d_done", 64'(done), 64'd1);
    ticks(3);
    chk("d_done_held", 64'(done), 64'd1);
    go = 1'b0;
    ticks(2);
    chk("d_done_clr", 64'(done), 64'd0);
    chk("d_busy", 64'(busy), 64'd0);

    // go dropped during DELAY: no writes, no done
    offset = 32'd4; max_s = 32'd3; go = 1'b1;
    ticks(2);
    go = 1'b0;
    ticks(8);
    chk("e_done", 64'(done), 64'd0);
    chk("e_busy", 64'(busy), 64'd0);

    // go dropped during CAPTURE: count retained
    offset = 32'd0; max_s = 32'd10; go = 1'b1;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    go = 1'b0;
    ticks(4);
    chk("f_count_kept", 64'(count), 64'd2);
    chk("f_done", 64'(done), 64'd0);

    // reset during CAPTURE: immediate abort, no further writes
    offset = 32'd0; max_s = 32'd10; go = 1'b1;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    @(negedge adc_clk);
    #1;
    reset = 1'b1;
    #1;
    chk("g_wr_en", 64'(wr_en), 64'd0);
    chk("g_busy", 64'(busy), 64'd0);
    chk("g_count", 64'(count), 64'd0);
    ticks(3);
    go = 1'b0;
    reset = 1'b0;
    ticks(4);
    chk("g_done", 64'(done), 64'd0);
    chk("g_sb_empty", 64'(sb.size()), 64'd0);

    // maximal offset is accepted and just keeps delaying
    offset = 32'hFFFF_FFFF; max_s = 32'd2; go = 1'b1;
    ticks(6);
    chk("h_busy", 64'(busy), 64'd1);
    chk("h_done", 64'(done), 64'd0);
    go = 1'b0;
    ticks(3);
    chk("h_idle", 64'(busy), 64'd0);

`ifdef ADC_CAPTURE_DOWNSAMPLE_EN
    // downsample 2, three samples: writes at CAPTURE cycles 0, 3, 6
    downsample = 16'd2; offset = 32'd0; max_s = 32'd3; go = 1'b1;
    tick(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    chk("i_done", 64'(done), 64'd1);
    chk("i_count", 64'(count), 64'd3);
    go = 1'b0;
    ticks(2);
`endif

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
